// File: rtl/posit_op_sequencer.sv
// Byte-serial command sequencer for a posit arithmetic core: it loads an opcode and two
// N-bit operands from an 8-bit bus, starts the core, and streams the result back MSB-first.
module posit_op_sequencer #(
   parameter int N       = 16,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic [7:0]   out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         err,
   output logic [1:0]   core_op,
   output logic [N-1:0] core_a,
   output logic [N-1:0] core_b,
   output logic         core_start,
   input  logic         core_done,
   input  logic [N-1:0] core_result
);

   localparam int NB = N / 8;
   localparam int BW = $clog2(NB) + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      START,
      WAIT,
      SEND
   } state_t;

   state_t        state;
   logic [BW-1:0] byte_cnt;
   logic [TW-1:0] tick_cnt;
   logic [N-1:0]  result;
   logic [N-1:0]  result_next;
   logic [N-1:0]  shift_a;
   logic [N-1:0]  shift_b;

   // Operands arrive MSB-first, so each new byte enters at the bottom and pushes older ones up.
   assign shift_a     = (core_a << 8) | N'(in_data);
   assign shift_b     = (core_b << 8) | N'(in_data);
   assign result_next = result << 8;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk) begin
      // NOTE: all state here is written with non-blocking assignments so every register
      // updates from the same pre-edge values regardless of statement order.
      if (!rst_n) begin
         state      <= IDLE;
         out_data   <= '0;
         out_valid  <= 1'b0;
         err        <= 1'b0;
         core_start <= 1'b0;
         core_op    <= '0;
         core_a     <= '0;
         core_b     <= '0;
         byte_cnt   <= '0;
         tick_cnt   <= '0;
         result     <= '0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  core_op  <= in_data[1:0];
                  err      <= 1'b0;
                  byte_cnt <= '0;
                  state    <= LOAD_A;
               end
            end
            LOAD_A: begin
               if (in_valid) begin
                  core_a <= shift_a;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt <= '0;
                     state    <= LOAD_B;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            LOAD_B: begin
               if (in_valid) begin
                  core_b <= shift_b;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt   <= '0;
                     core_start <= 1'b1;
                     state      <= START;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            START: begin
               core_start <= 1'b0;
               tick_cnt   <= '0;
               state      <= WAIT;
            end
            WAIT: begin
               // A done pulse on the timeout edge still delivers its result.
               if (core_done) begin
                  result    <= core_result;
                  out_data  <= core_result[N-1 -: 8];
                  out_valid <= 1'b1;
                  byte_cnt  <= '0;
                  state     <= SEND;
               end else if (tick_cnt == LAST_TICK) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (byte_cnt == LAST_BYTE) begin
                     out_valid <= 1'b0;
                     out_data  <= '0;
                     state     <= IDLE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                     result   <= result_next;
                     out_data <= result_next[N-1 -: 8];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
